// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the snake game controller.
package snake_pkg;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned NUM_LEN = 10;
  localparam int unsigned GRID_W  = 32;

  typedef enum logic [1:0] {
    DirLeft  = 2'b00,
    DirRight = 2'b01,
    DirUp    = 2'b10,
    DirDown  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StCheck = 2'b10,
    StOver  = 2'b11
  } state_e;

  // Opposite directions share the axis bit and differ only in bit 0.
  function automatic logic is_reverse(dir_e a, dir_e b);
    return (a ^ b) == 2'b01;
  endfunction

  function automatic dir_e btn_to_dir(logic [3:0] btn);
    if (btn[0])      return DirLeft;
    else if (btn[1]) return DirRight;
    else if (btn[2]) return DirUp;
    else             return DirDown;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Step timer: counts 0..period-1 while enabled and strobes tick_o on the wrap.
module snake_tick_gen #(
  parameter int unsigned CntW = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [CntW-1:0] period_i,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // >= rather than == so a period shortened mid-count still wraps.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q >= period_i - 1'b1) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: start/over handling, direction commit, food scoring.
// Define SNAKE_SPEEDUP_EN to shorten the step period after each food eaten.
module snake_game_ctrl #(
  parameter int unsigned MAX_LEN  = snake_pkg::MAX_LEN,
  parameter int unsigned NUM_LEN  = snake_pkg::NUM_LEN,
  parameter int unsigned INIT_LEN = 5,
  parameter int unsigned TICK_DIV = 25000000,
  // Wide enough to hold MAX_LEN itself.
  localparam int unsigned LenW    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start_i,
  input  logic [3:0]         btn_dir_i,
  input  logic [NUM_LEN-1:0] head_pos_i,
  input  logic               snake_stop_i,
  input  logic [NUM_LEN-1:0] food_pos_i,
  output logic               step_o,
  output logic [1:0]         di_o,
  output logic [LenW-1:0]    len_o,
  output logic               food_eaten_o,
  output logic [1:0]         state_o,
  output logic [7:0]         score_o
);

  import snake_pkg::*;

  localparam int unsigned     CntW       = $clog2(TICK_DIV + 1);
  localparam logic [CntW-1:0] PeriodInit = CntW'(TICK_DIV);
  localparam logic [LenW-1:0] LenInit    = LenW'(INIT_LEN);
  localparam logic [LenW-1:0] LenMax     = LenW'(MAX_LEN);

  state_e          state_q, state_d;
  dir_e            di_q, di_d, pend_q, pend_d, btn_dir;
  logic [LenW-1:0] len_q, len_d;
  logic [7:0]      score_q, score_d;
  logic            step_q, step_d, food_q, food_d, start_q;
  logic            start_rise, game_start, tick, tick_en;
  logic [CntW-1:0] period_q;

  assign start_rise = btn_start_i & ~start_q;
  assign game_start = (state_q == StIdle) & start_rise;
  assign btn_dir    = btn_to_dir(btn_dir_i);
  // Timer keeps running through the one-cycle CHECK so steps stay exactly period apart.
  assign tick_en    = (state_q == StRun) | (state_q == StCheck);

  snake_tick_gen #(
    .CntW(CntW)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (tick_en),
    .clr_i   (game_start),
    .period_i(period_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    di_d    = di_q;
    pend_d  = pend_q;
    len_d   = len_q;
    score_d = score_q;
    step_d  = 1'b0;
    food_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d = StRun;
          di_d    = DirRight;
          pend_d  = DirRight;
          len_d   = LenInit;
          score_d = '0;
        end
      end
      StRun: begin
        if (step_q) state_d = StCheck;
        if (tick) begin
          step_d = 1'b1;
          di_d   = pend_q;
        end
        // Reversal is judged against the direction that will be committed after this edge.
        if (btn_dir_i != 4'b0000 && !is_reverse(btn_dir, di_d)) pend_d = btn_dir;
      end
      StCheck: begin
        if (snake_stop_i) begin
          state_d = StOver;
        end else begin
          state_d = StRun;
          if (head_pos_i == food_pos_i) begin
            food_d = 1'b1;
            if (len_q < LenMax)     len_d   = len_q + 1'b1;
            if (score_q != 8'hFF)   score_d = score_q + 1'b1;
          end
        end
      end
      StOver: begin
        if (btn_start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      di_q    <= DirRight;
      pend_q  <= DirRight;
      len_q   <= LenInit;
      score_q <= '0;
      step_q  <= 1'b0;
      food_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      di_q    <= di_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      score_q <= score_d;
      step_q  <= step_d;
      food_q  <= food_d;
      start_q <= btn_start_i;
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CntW-1:0] PeriodDec = CntW'(TICK_DIV / 16);
  localparam logic [CntW-1:0] PeriodMin = CntW'(TICK_DIV / 4);

  logic [CntW-1:0] period_d;

  always_comb begin
    period_d = period_q;
    if (game_start) begin
      period_d = PeriodInit;
    end else if (food_d) begin
      period_d = (period_q >= PeriodMin + PeriodDec) ? period_q - PeriodDec : PeriodMin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= PeriodInit;
    end else begin
      period_q <= period_d;
    end
  end
`else
  assign period_q = PeriodInit;
`endif

  assign step_o       = step_q;
  assign di_o         = di_q;
  assign len_o        = len_q;
  assign food_eaten_o = food_q;
  assign state_o      = state_q;
  assign score_o      = score_q;

endmodule
